// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//
// Instruction-fetch stage of the MIPS pipeline. It owns the PC and issues word
// fetches to a variable-latency instruction memory over a req/ready handshake.
// The fetched instruction and PC+4 go to the IF/ID register. The stage honours
// stall, applies branch/jump redirects from ID, and drives IF/ID's active-low
// flush.
//
// Ports:
//   clk, rst                 pipeline clock, synchronous active-high reset
//   stall                    IF/ID will not load this cycle
//   redirect, redirect_pc    taken branch/jump from ID and its target
//   imem_req, imem_addr      fetch request and word address
//   imem_ready, imem_rdata   response strobe and instruction data
//   pc_inc_o, instr_o        fetched PC+4 and instruction to IF/ID
//   valid_o                  pc_inc_o/instr_o carry a real instruction
//   flush_n_o                active-low flush to IF/ID
//
// States:
//   S_FETCH | request outstanding at pc; a response is accepted or redirected
//   S_HOLD  | response arrived under stall; presented from hold_instr_q
//   S_DRAIN | redirect hit an outstanding request; wait, discard, go to target

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_inc_o,
    output logic [31:0] instr_o,
    output logic        valid_o,
    output logic        flush_n_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    logic [31:0] redir_pc_w;
    logic [31:0] pc_plus4_w;

    // Low two bits of the target are ignored so pc stays word aligned.
    assign redir_pc_w = {redirect_pc[31:2], 2'b00};
    assign pc_plus4_w = pc_q + 32'd4;

    // Combinational outputs
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        instr_o   = 32'h0;
        pc_inc_o  = 32'h0;
        valid_o   = 1'b0;
        flush_n_o = 1'b1;
        if (rst) begin
            flush_n_o = 1'b0;
        end else begin
            // Redirect forces a bubble and a flush regardless of state.
            flush_n_o = ~redirect;
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready && !redirect) begin
                        instr_o  = imem_rdata;
                        pc_inc_o = pc_plus4_w;
                        valid_o  = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!redirect) begin
                        instr_o  = hold_instr_q;
                        pc_inc_o = pc_plus4_w;
                        valid_o  = 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Address must not move while the old request is pending.
                    imem_req = 1'b1;
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        target_d     = target_q;
        hold_instr_d = hold_instr_q;
        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    if (imem_ready) begin
                        pc_d = redir_pc_w;
                    end else begin
                        target_d = redir_pc_w;
                        state_d  = S_DRAIN;
                    end
                end else if (imem_ready) begin
                    if (stall) begin
                        hold_instr_d = imem_rdata;
                        state_d      = S_HOLD;
                    end else begin
                        pc_d = pc_plus4_w;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redir_pc_w;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    pc_d    = pc_plus4_w;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    // Latest redirect wins, even in the cycle the drain completes.
                    target_d = redir_pc_w;
                    if (imem_ready) begin
                        pc_d    = redir_pc_w;
                        state_d = S_FETCH;
                    end
                end else if (imem_ready) begin
                    pc_d    = target_q;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            target_q     <= RESET_PC;
            hold_instr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            target_q     <= target_d;
            hold_instr_q <= hold_instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. Inputs change 1 time unit after posedge;
// outputs are checked 1 time unit later, well before the next posedge.
// The memory model returns the word address as data unless overridden.

module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_inc_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic        flush_n_o;

    logic        ovr_en;
    logic [31:0] ovr_data;

    int n_chk  = 0;
    int n_fail = 0;

    assign imem_rdata = ovr_en ? ovr_data : imem_addr;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc_inc_o   (pc_inc_o),
        .instr_o    (instr_o),
        .valid_o    (valid_o),
        .flush_n_o  (flush_n_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] ins,
                           input logic [31:0] pinc, input logic fln);
        chk({tag, ".req"},     {31'h0, imem_req},  {31'h0, req});
        chk({tag, ".addr"},    imem_addr,          addr);
        chk({tag, ".valid"},   {31'h0, valid_o},   {31'h0, vld});
        chk({tag, ".instr"},   instr_o,            ins);
        chk({tag, ".pc_inc"},  pc_inc_o,           pinc);
        chk({tag, ".flush_n"}, {31'h0, flush_n_o}, {31'h0, fln});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b0; ovr_en = 1'b0; ovr_data = 32'h0;

        // Reset
        tick();
        settle();
        chk("rst.req",     {31'h0, imem_req},  32'h0);
        chk("rst.valid",   {31'h0, valid_o},   32'h0);
        chk("rst.instr",   instr_o,            32'h0);
        chk("rst.pc_inc",  pc_inc_o,           32'h0);
        chk("rst.flush_n", {31'h0, flush_n_o}, 32'h0);
        rst = 1'b0;
        tick();

        // Zero-wait stream: one instruction per cycle
        imem_ready = 1'b1;
        settle();
        chk_out("zw0", 1'b1, 32'd0,  1'b1, 32'd0,  32'd4,  1'b1);
        tick(); settle();
        chk_out("zw1", 1'b1, 32'd4,  1'b1, 32'd4,  32'd8,  1'b1);
        tick(); settle();
        chk_out("zw2", 1'b1, 32'd8,  1'b1, 32'd8,  32'd12, 1'b1);
        tick(); settle();
        chk_out("zw3", 1'b1, 32'd12, 1'b1, 32'd12, 32'd16, 1'b1);
        tick();

        // 2-wait memory: address held 3 cycles, one valid pulse
        imem_ready = 1'b0;
        settle();
        chk_out("w2a0", 1'b1, 32'd16, 1'b0, 32'd0,  32'd0,  1'b1);
        tick(); settle();
        chk_out("w2a1", 1'b1, 32'd16, 1'b0, 32'd0,  32'd0,  1'b1);
        tick(); imem_ready = 1'b1; settle();
        chk_out("w2a2", 1'b1, 32'd16, 1'b1, 32'd16, 32'd20, 1'b1);
        tick(); imem_ready = 1'b0; settle();
        chk_out("w2b0", 1'b1, 32'd20, 1'b0, 32'd0,  32'd0,  1'b1);
        tick(); settle();
        chk_out("w2b1", 1'b1, 32'd20, 1'b0, 32'd0,  32'd0,  1'b1);
        tick(); imem_ready = 1'b1; settle();
        chk_out("w2b2", 1'b1, 32'd20, 1'b1, 32'd20, 32'd24, 1'b1);
        tick();

        // Zero-wait redirect to 8: data discarded, target fetched next cycle
        redirect = 1'b1; redirect_pc = 32'd8;
        settle();
        chk_out("rd8", 1'b1, 32'd24, 1'b0, 32'd0, 32'd0, 1'b0);
        tick(); redirect = 1'b0;

        // Stall on response at 8
        stall = 1'b1; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        settle();
        chk_out("st0", 1'b1, 32'd8, 1'b1, 32'hDEAD_BEEF, 32'd12, 1'b1);
        tick(); ovr_en = 1'b0; imem_ready = 1'b0; settle();
        chk_out("st1", 1'b0, 32'd8, 1'b1, 32'hDEAD_BEEF, 32'd12, 1'b1);
        tick(); settle();
        chk_out("st2", 1'b0, 32'd8, 1'b1, 32'hDEAD_BEEF, 32'd12, 1'b1);
        tick(); stall = 1'b0; settle();
        chk_out("st3", 1'b0, 32'd8, 1'b1, 32'hDEAD_BEEF, 32'd12, 1'b1);
        tick(); imem_ready = 1'b1; settle();
        chk_out("st4", 1'b1, 32'd12, 1'b1, 32'd12, 32'd16, 1'b1);

        // Redirect to 0x20 (zero wait) to set up the drain case
        redirect = 1'b1; redirect_pc = 32'h20;
        tick(); redirect = 1'b0; imem_ready = 1'b0;

        // Redirect while 0x20 outstanding, second redirect during drain
        redirect = 1'b1; redirect_pc = 32'h100;
        settle();
        chk_out("dr0", 1'b1, 32'h20, 1'b0, 32'd0, 32'd0, 1'b0);
        tick(); redirect = 1'b0; settle();
        chk_out("dr1", 1'b1, 32'h20, 1'b0, 32'd0, 32'd0, 1'b1);
        tick(); redirect = 1'b1; redirect_pc = 32'h200; settle();
        chk_out("dr2", 1'b1, 32'h20, 1'b0, 32'd0, 32'd0, 1'b0);
        tick(); redirect = 1'b0; imem_ready = 1'b1; settle();
        chk_out("dr3", 1'b1, 32'h20, 1'b0, 32'd0, 32'd0, 1'b1);
        tick(); imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100; settle();
        chk_out("dr4", 1'b1, 32'h200, 1'b0, 32'd0, 32'd0, 1'b0);
        tick(); redirect = 1'b0; imem_ready = 1'b1; settle();
        chk_out("dr5", 1'b1, 32'h200, 1'b0, 32'd0, 32'd0, 1'b1);
        tick(); settle();
        chk_out("dr6", 1'b1, 32'h100, 1'b1, 32'h100, 32'h104, 1'b1);

        // Turn that cycle into a redirect to 0x40 instead of accepting
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();

        // Redirect + stall + ready together at 0x40
        redirect_pc = 32'h80; stall = 1'b1;
        settle();
        chk_out("rs0", 1'b1, 32'h40, 1'b0, 32'd0, 32'd0, 1'b0);
        tick(); redirect = 1'b0; stall = 1'b0; settle();
        chk_out("rs1", 1'b1, 32'h80, 1'b1, 32'h80, 32'h84, 1'b1);

        // Unaligned target: low bits ignored
        redirect = 1'b1; redirect_pc = 32'h83;
        tick(); redirect = 1'b0; settle();
        chk("ua.addr", imem_addr, 32'h80);

        // Wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); redirect = 1'b0; settle();
        chk_out("wr0", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b1);
        tick(); settle();
        chk_out("wr1", 1'b1, 32'h0, 1'b1, 32'h0, 32'h4, 1'b1);

        // Mid-wait reset: request at 4 abandoned
        tick(); imem_ready = 1'b0; settle();
        chk_out("mr0", 1'b1, 32'h4, 1'b0, 32'd0, 32'd0, 1'b1);
        tick(); rst = 1'b1; imem_ready = 1'b1; settle();
        chk("mr1.req",     {31'h0, imem_req},  32'h0);
        chk("mr1.flush_n", {31'h0, flush_n_o}, 32'h0);
        chk("mr1.valid",   {31'h0, valid_o},   32'h0);
        tick(); rst = 1'b0; settle();
        chk_out("mr2", 1'b1, 32'h0, 1'b1, 32'h0, 32'h4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the MIPS pipeline. It sits directly upstream of the IF/ID pipeline register and owns the PC. It issues word fetches to a variable-latency instruction memory over a req/ready handshake and presents the fetched instruction with PC+4 to IF/ID. It honours pipeline stall, applies branch/jump redirects from ID, and drives IF/ID's active-low flush.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: IF/ID will not load this cycle.
- redirect  in  1  taken branch/jump resolved in ID this cycle.
- redirect_pc  in  32  target; bits [1:0] ignored (treated as 00).
- imem_req  out  1  fetch request.
- imem_addr  out  32  word address; stable while imem_req is high and imem_ready is low.
- imem_ready  in  1  response valid this cycle; completes the request.
- imem_rdata  in  32  instruction, valid when imem_ready is high.
- pc_inc_o  out  32  fetched PC + 4, to IF/ID PC_Inc input.
- instr_o  out  32  instruction to IF/ID; 32'h0 (NOP) when no valid instruction.
- valid_o  out  1  instr_o/pc_inc_o carry a real instruction this cycle.
- flush_n_o  out  1  active-low flush to IF/ID.

## Operation
- Registers:
  - pc: address of the current or outstanding fetch.
  - target: pending redirect address.
  - hold_instr: skid buffer for a response that arrived under stall.
  - state.
- States: FETCH, HOLD, DRAIN.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Accept: imem_ready=1 and redirect=0.
    - instr_o=imem_rdata, pc_inc_o=pc+4, valid_o=1, combinationally in the same cycle.
    - If stall=0: pc<=pc+4, stay in FETCH.
    - If stall=1: hold_instr<=imem_rdata, go to HOLD.
  - imem_ready=0: outputs are a bubble (instr_o=0, pc_inc_o=0, valid_o=0).
- HOLD:
  - imem_req=0.
  - Outputs: instr_o=hold_instr, pc_inc_o=pc+4, valid_o=1.
  - stall=0: pc<=pc+4, go to FETCH.
- DRAIN:
  - imem_req=1, imem_addr=pc (the old address; the handshake forbids changing it).
  - Outputs are a bubble.
  - On imem_ready: data is discarded, pc<=target, go to FETCH.
- Redirect, which has priority over stall in every state:
  - flush_n_o=0 in that same cycle.
  - Outputs are forced to a bubble that cycle.
  - FETCH with imem_ready=1: data discarded, pc<=redirect_pc, stay in FETCH.
  - FETCH with imem_ready=0: target<=redirect_pc, go to DRAIN.
  - HOLD: buffer dropped, pc<=redirect_pc, go to FETCH.
  - DRAIN: target<=redirect_pc (latest wins); if imem_ready=1 in that cycle, pc<=redirect_pc and go to FETCH.
- flush_n_o=1 whenever there is no redirect and no rst.
- Arithmetic: 32-bit unsigned modulo; 32'hFFFF_FFFC + 4 = 32'h0. Low two bits of pc are always 0.

## Timing
- Reset (rst=1 at an edge):
  - pc<=RESET_PC, target<=RESET_PC, hold_instr<=0, state<=FETCH.
  - While rst=1: imem_req=0, instr_o=0, pc_inc_o=0, valid_o=0, flush_n_o=0.
- First cycle after rst falls: imem_req=1, imem_addr=RESET_PC.
- rst mid-request: the outstanding response is abandoned. The memory must tolerate req dropping; the response in the reset cycle is ignored.
- Throughput:
  - Zero-wait memory (ready in the same cycle as req): one instruction per cycle.
  - N-cycle memory: one instruction per N+1 cycles (bubbles in between).
- Fetch latency: the instruction is visible to IF/ID combinationally in the ready cycle and is latched at the next edge.
- Stall-to-resume: the held instruction is presented until the first cycle with stall=0. The next fetch is issued the cycle after that.
- Redirect penalty:
  - Zero wait: the target is fetched in the cycle after redirect.
  - Outstanding request: the target is fetched the cycle after the drained response.
- Outputs may combinationally depend on imem_ready, imem_rdata, stall and redirect. There are no paths from outputs back to inputs.

## Test plan
- Reset + zero-wait stream (RESET_PC=0, ready tied high, memory returns addr): imem_addr 0,4,8,12 on consecutive cycles; pc_inc_o 4,8,12,16; valid_o=1 each cycle.
- 2-wait memory: each address is held for 3 cycles with req=1; valid_o pulses once per 3 cycles; instr_o=0 in bubble cycles.
- Stall on response (addr 8 returns 0xDEADBEEF, stall=1 for 3 cycles): HOLD with instr_o=0xDEADBEEF and pc_inc_o=12 throughout; imem_req=0; after stall falls, next imem_addr=12.
- Redirect during outstanding fetch (addr 0x20 pending, redirect_pc=0x100): flush_n_o=0 for one cycle; imem_addr remains 0x20 until ready; that data is discarded (valid_o=0); next imem_addr=0x100. A second redirect to 0x200 during DRAIN makes the next address 0x200.
- Simultaneous redirect+stall+ready at addr 0x40 (redirect_pc=0x80): data discarded, flush_n_o=0, next cycle imem_addr=0x80. Also: redirect_pc=0x83 gives imem_addr=0x80.
- Wrap and mid-run reset: redirect to 0xFFFFFFFC, pc_inc_o=0, next imem_addr=0; rst asserted mid-wait gives req=0 and flush_n_o=0, then a fetch from RESET_PC after release.
